// File: rtl/start_delay_pkg.sv
// Shared types and sizing helpers for the starting-line reaction timer.
package start_delay_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLights,
        StHold,
        StGo,
        StDone,
        StFault
    } state_e;

    localparam int unsigned REACT_W = 14;

    // Largest of two unsigned values, for sizing counters at elaboration.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed for the hold delay: BASE + 127 * STEP must fit.
    function automatic int unsigned delay_width(input int unsigned base_ms,
                                                input int unsigned step_ms);
        int unsigned max_ms;
        max_ms = base_ms + 127 * step_ms;
        return (max_ms > 0) ? $clog2(max_ms + 1) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider: counts 0..TICK_DIV-1 and flags the wrap cycle.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_arstn,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The tick is not masked by i_clr: the consumer may use this very tick to
    // decide the transition that raises i_clr, so masking would form a loop.
    assign o_tick = (cnt_q == CNT_LAST);

    // Next count: wrap at the end of the period, restart on clear.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/start_delay_sequencer.sv
// Starting-light sequencer: lights, random hold, go, reaction timing and
// false-start detection. All outputs come straight from registers.
module start_delay_sequencer
    import start_delay_pkg::*;
#(
    parameter int unsigned TICK_DIV          = 50000,
    parameter int unsigned N_LIGHTS          = 5,
    parameter int unsigned LIGHT_INTERVAL_MS = 1000,
    parameter int unsigned DELAY_BASE_MS     = 200,
    parameter int unsigned DELAY_STEP_MS     = 8,
    parameter int unsigned MAX_REACT_MS      = 9999
) (
    input  logic                i_clk,
    input  logic                i_arstn,
    input  logic                i_start,
    input  logic                i_button,
    input  logic [6:0]          i_randomValue,
    output logic                o_prbsEn,
    output logic [N_LIGHTS-1:0] o_lights,
    output logic [REACT_W-1:0]  o_reactionMs,
    output logic                o_valid,
    output logic                o_falseStart,
    output logic                o_busy
);

    localparam int unsigned DLY_W   = delay_width(DELAY_BASE_MS, DELAY_STEP_MS);
    localparam int unsigned DLY_MAX = DELAY_BASE_MS + 127 * DELAY_STEP_MS;
    localparam int unsigned MS_MAX  = max_u(max_u(LIGHT_INTERVAL_MS, DLY_MAX), MAX_REACT_MS);
    localparam int unsigned MS_W    = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;

    localparam logic [MS_W-1:0]    LIGHT_MS  = MS_W'(LIGHT_INTERVAL_MS);
    localparam logic [MS_W-1:0]    SAT_MS    = MS_W'(MAX_REACT_MS);
    localparam logic [REACT_W-1:0] SAT_REACT = REACT_W'(MAX_REACT_MS);

    state_e                state_q, state_d;
    logic [N_LIGHTS-1:0]   lights_q, lights_d, lights_shift;
    logic [REACT_W-1:0]    react_q, react_d;
    logic                  valid_q, valid_d;
    logic                  fs_q, fs_d;
    logic                  busy_q, busy_d;
    logic                  prbs_en_q, prbs_en_d;
    logic [MS_W-1:0]       ms_q, ms_d, ms_inc;
    logic [DLY_W-1:0]      delay_q, delay_d, delay_new;
    logic                  tick;
    logic                  clr;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_arstn(i_arstn),
        .i_clr  (clr),
        .o_tick (tick)
    );

    // ms_inc is the count this tick would produce; comparing it lets the
    // transition land on the edge where the count reaches its target.
    assign ms_inc       = ms_q + MS_W'(1);
    assign lights_shift = {lights_q[N_LIGHTS-2:0], 1'b1};
    assign delay_new    = DLY_W'(DELAY_BASE_MS) + DLY_W'(i_randomValue) * DLY_W'(DELAY_STEP_MS);

    // Next-state, ms counter and output decode.
    always_comb begin
        state_d  = state_q;
        lights_d = lights_q;
        react_d  = react_q;
        valid_d  = valid_q;
        fs_d     = fs_q;
        delay_d  = delay_q;
        ms_d     = tick ? ms_inc : ms_q;

        unique case (state_q)
            StIdle, StDone, StFault: begin
                // Buttons are ignored while waiting.
                if (i_start) begin
                    state_d  = StLights;
                    lights_d = '0;
                    valid_d  = 1'b0;
                    fs_d     = 1'b0;
                end
            end
            StLights: begin
                // A button beats a simultaneous light step.
                if (i_button) begin
                    state_d  = StFault;
                    lights_d = '1;
                    valid_d  = 1'b0;
                    fs_d     = 1'b1;
                end else if (tick && (ms_inc == LIGHT_MS)) begin
                    lights_d = lights_shift;
                    ms_d     = '0;
                    if (lights_shift[N_LIGHTS-1]) begin
                        state_d = StHold;
                        delay_d = delay_new;
                    end
                end
            end
            StHold: begin
                // A button on the go edge is still a false start.
                if (i_button) begin
                    state_d  = StFault;
                    lights_d = '1;
                    valid_d  = 1'b0;
                    fs_d     = 1'b1;
                end else if (tick && (ms_inc >= MS_W'(delay_q))) begin
                    state_d  = StGo;
                    lights_d = '0;
                end
            end
            StGo: begin
                // A button on the saturation cycle reports the running count.
                if (i_button) begin
                    state_d = StDone;
                    react_d = REACT_W'(ms_q);
                    valid_d = 1'b1;
                end else if (tick && (ms_inc == SAT_MS)) begin
                    state_d = StDone;
                    react_d = SAT_REACT;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every state entry restarts both the tick phase and the ms count.
        clr = (state_d != state_q);
        if (clr) begin
            ms_d = '0;
        end

        busy_d    = (state_d == StLights) || (state_d == StHold) || (state_d == StGo);
        prbs_en_d = !busy_d;
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q   <= StIdle;
            lights_q  <= '0;
            react_q   <= '0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
            prbs_en_q <= 1'b1;
            ms_q      <= '0;
            delay_q   <= '0;
        end else begin
            state_q   <= state_d;
            lights_q  <= lights_d;
            react_q   <= react_d;
            valid_q   <= valid_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
            prbs_en_q <= prbs_en_d;
            ms_q      <= ms_d;
            delay_q   <= delay_d;
        end
    end

    assign o_prbsEn     = prbs_en_q;
    assign o_lights     = lights_q;
    assign o_reactionMs = react_q;
    assign o_valid      = valid_q;
    assign o_falseStart = fs_q;
    assign o_busy       = busy_q;

endmodule
